cont_assign_delay_sched: RTL and testbench
==========================================

# cont_assign_delay_sched

Clocked scheduler that reproduces delayed continuous-assignment semantics (`assign #D w = a & b`) in synthesizable form. It samples the right-hand side every cycle, queues each value change with a programmable cycle delay, and retires the changes onto `w` in order. It serves as the reference model and driver for delayed-net checks in the assignment test benches. A configuration handshake changes the delay, but only while no events are pending.

## Interface
- `DELAY`, 10: reset delay in clock cycles (1..2^CW-1).
- `DEPTH`, 4: maximum number of pending events (≥2).
- `CW`, 8: width of the delay counter and configuration field.
- `clk  in  1`: clock; all state changes on the rising edge.
- `rst_n  in  1`: one clock; reset is asynchronous and active-low.
- `a  in  1`: RHS operand.
- `b  in  1`: RHS operand.
- `cfg_valid  in  1`: new delay offered.
- `cfg_delay  in  CW`: requested delay; 0 is treated as 1.
- `cfg_ready  out  1`: delay may be loaded; asserted when the queue is empty.
- `w  out  1`: delayed net value.
- `pending  out  $clog2(DEPTH+1)`: number of queued events.
- `overflow  out  1`: sticky; an event was collapsed because the queue was full.

## Operation
- `rhs = a & b` is sampled at every edge.
- `last_sched` holds the most recently scheduled value, or `w` when the queue is empty.
- A change is detected when `rhs != last_sched`. On a change, enqueue `{value=rhs, cnt=delay_q}` at the tail and update `last_sched`.
- Every edge, `cnt` decrements in all valid entries.
- When the head entry's `cnt == 1` at an edge: `w <= head.value` and the head is popped.
- States:
  - IDLE (`pending == 0`): `cfg_ready = 1`.
  - BUSY (`pending > 0`): `cfg_ready = 0`.
  - IDLE→BUSY on enqueue. BUSY→IDLE when the last entry pops with no enqueue in the same edge.
- Config handshake: when `cfg_valid && cfg_ready` at an edge, `delay_q <= max(cfg_delay, 1)` and `overflow` is cleared.
  - An enqueue in that same edge uses the old `delay_q`.
  - Loading only while the queue is empty keeps queue order monotonic.
- Push and pop in the same edge are both performed, and `pending` is unchanged. On a full queue, a pop frees a slot, so a simultaneous push is legal.
- Full queue with a push and no pop:
  - The tail entry is overwritten with the new value and a fresh `cnt = delay_q`.
  - `overflow <= 1`.
  - `pending` stays at DEPTH.
- Enqueue is limited to one event per cycle. Events with equal delays never collide.
- Reset, asynchronous and taking effect mid-operation:
  - All queued events are discarded.
  - `w = 0`, `last_sched = 0`, `pending = 0`, `overflow = 0`, `delay_q = DELAY`, `cfg_ready = 1`.

## Timing
- A change sampled at edge k appears on `w` after edge k+D, where D is `delay_q` at edge k. Minimum latency is 1 cycle.
- A pulse of width P cycles on `rhs` produces two events, so `w` shows the same P-cycle pulse delayed by D (transport), provided the queue has room.
- `pending`, `cfg_ready`, and `overflow` are registered or decoded from registered state; no combinational path from `a`/`b` to any output.
- `cfg_ready` depends on state only, never on `cfg_valid`.

## Configuration
- Macro: `CONT_ASSIGN_DELAY_SCHED_INERTIAL_EN`.
- Undefined (default): transport semantics as described above.
- Defined: inertial semantics.
  - A detected change flushes all pending entries.
  - If the new `rhs` equals the current `w`, the queue is left empty; the glitch is suppressed and the machine returns to IDLE.
  - Otherwise, exactly one entry `{rhs, delay_q}` is queued.
  - `pending` never exceeds 1 and `overflow` is never set.

## Test plan
- Reset, then `a=b=1` at edge 5 with DELAY=10: `w` rises after edge 15; `pending` is 1 during edges 5..14 and 0 after.
- Handshake `cfg_delay=3` while idle, then toggle `rhs` 0→1 at edge 20: `w=1` after edge 23. A `cfg_valid` asserted while `pending>0` is ignored and `cfg_ready=0` throughout.
- D=10, 2-cycle pulse on `rhs` at edges 30–31 (transport build): `w` is high exactly after edges 40–41, and two events are queued.
- DEPTH=4, D=10, `rhs` toggling every cycle for 6 cycles: `pending` saturates at 4, `overflow=1`, and the final `w` equals the final `rhs`. A later config handshake clears `overflow`.
- Inertial build, D=5, 2-cycle pulse: `w` never changes and `pending` returns to 0 two cycles after the pulse starts. A 7-cycle pulse appears on `w` delayed by 5.
- Assert `rst_n=0` mid-BUSY with 3 pending events: `w`, `pending`, and `overflow` go to 0 immediately, with no later spurious `w` transitions.

Source files
------------

// File: rtl/cont_assign_delay_sched.sv
// Clocked model of `assign #D w = a & b`: RHS changes are queued with a cycle delay and retired in order.
// Define CONT_ASSIGN_DELAY_SCHED_INERTIAL_EN for inertial (glitch-suppressing) instead of transport semantics.
module cont_assign_delay_sched #(
  parameter int DELAY = 10,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       a,
  input  logic                       b,
  input  logic                       cfg_valid,
  input  logic [CW-1:0]              cfg_delay,
  output logic                       cfg_ready,
  output logic                       w,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       overflow
);
  localparam int PW = $clog2(DEPTH+1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q;
  logic            w_q, w_d;
  logic            last_q, last_d;
  logic            ovf_q, ovf_d;
  logic [CW-1:0]   delay_q, delay_d;
  logic [PW-1:0]   pend_q, pend_d, pend_pop;
  logic            val_q  [DEPTH];
  logic            val_d  [DEPTH];
  logic            sh_val [DEPTH];
  logic [CW-1:0]   cnt_q  [DEPTH];
  logic [CW-1:0]   cnt_d  [DEPTH];
  logic [CW-1:0]   sh_cnt [DEPTH];
  logic            rhs, change, pop, cfg_fire;

  assign rhs      = a & b;
  assign change   = (rhs != last_q);
  assign pop      = (pend_q != '0) && (cnt_q[0] == CW'(1));
  assign cfg_fire = cfg_valid && cfg_ready;
  assign pend_pop = pend_q - PW'(pop);

  // Slot 0 is always the head; a pop shifts every entry one slot toward it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    if (gi < DEPTH-1) begin : g_mid
      assign sh_val[gi] = pop ? val_q[gi+1] : val_q[gi];
      assign sh_cnt[gi] = (pop ? cnt_q[gi+1] : cnt_q[gi]) - CW'(1);
    end else begin : g_last
      assign sh_val[gi] = val_q[gi];
      assign sh_cnt[gi] = cnt_q[gi] - CW'(1);
    end
  end

  always_comb begin
    w_d     = pop ? val_q[0] : w_q;
    last_d  = change ? rhs : last_q;
    val_d   = sh_val;
    cnt_d   = sh_cnt;
    pend_d  = pend_pop;
    ovf_d   = cfg_fire ? 1'b0 : ovf_q;
    delay_d = cfg_fire ? ((cfg_delay == '0) ? CW'(1) : cfg_delay) : delay_q;
`ifdef CONT_ASSIGN_DELAY_SCHED_INERTIAL_EN
    // Any change cancels what is in flight; re-arm only if it differs from the net's value.
    if (change) begin
      pend_d = '0;
      if (rhs != w_d) begin
        val_d[0] = rhs;
        cnt_d[0] = delay_q;
        pend_d   = PW'(1);
      end
    end
`else
    if (change) begin
      if ((pend_q == PW'(DEPTH)) && !pop) begin
        val_d[DEPTH-1] = rhs;
        cnt_d[DEPTH-1] = delay_q;
        ovf_d          = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (pend_pop == PW'(i)) begin
            val_d[i] = rhs;
            cnt_d[i] = delay_q;
          end
        end
        pend_d = pend_pop + PW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      delay_q <= CW'(DELAY);
      pend_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        val_q[i] <= 1'b0;
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= (pend_d != '0) ? BUSY : IDLE;
      w_q     <= w_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      delay_q <= delay_d;
      pend_q  <= pend_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign w         = w_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_cont_assign_delay_sched.sv
// Scoreboard bench: stimulus pushes expected {edge, value} events for w; a negedge monitor pops on every w change.
module tb_cont_assign_delay_sched;
  localparam int CW    = 8;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH+1);
`ifdef CONT_ASSIGN_DELAY_SCHED_INERTIAL_EN
  localparam int EXP_RST_PEND = 1;
`else
  localparam int EXP_RST_PEND = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a = 1'b0;
  logic          b = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [CW-1:0] cfg_delay = '0;
  logic          cfg_ready, w, overflow;
  logic [PW-1:0] pending;

  typedef struct {
    int   edge_n;
    logic val;
  } ev_t;

  ev_t  sbq[$];
  ev_t  mon_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic w_prev = 1'b0;

  cont_assign_delay_sched #(.DELAY(10), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .cfg_valid(cfg_valid), .cfg_delay(cfg_delay), .cfg_ready(cfg_ready),
    .w(w), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      w_prev <= w;
    end else if (w !== w_prev) begin
      w_prev <= w;
      if (sbq.size() == 0) begin
        chk("spurious_w_change", int'(w), int'(w_prev));
      end else begin
        mon_e = sbq.pop_front();
        $display("w event: edge=%0d w=%0d (expected edge=%0d w=%0d)", cyc, w, mon_e.edge_n, mon_e.val);
        chk("w_edge", cyc, mon_e.edge_n);
        chk("w_val", int'(w), int'(mon_e.val));
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a change of rhs sampled at the next edge and record when it must reach w.
  task automatic chg(logic va, logic vb, int d);
    ev_t e;
    a = va;
    b = vb;
    e.edge_n = cyc + 1 + d;
    e.val    = va & vb;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic cfg(logic [CW-1:0] d);
    cfg_valid = 1'b1;
    cfg_delay = d;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int i;
    i = 0;
    while ((pending != '0 || sbq.size() != 0) && i < 100) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk(name, int'(pending == '0 && sbq.size() == 0), 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_w", int'(w), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    while (cyc < 4) @(negedge clk);

    // Default delay 10: change sampled at edge 5 reaches w after edge 15.
    chg(1'b1, 1'b1, 10);
    chk("t1_pending_busy", int'(pending), 1);
    chk("t1_cfg_ready_busy", int'(cfg_ready), 0);
    tick(9);
    chk("t1_pending_edge14", int'(pending), 1);
    tick(1);
    #1;
    chk("t1_pending_after", int'(pending), 0);
    chk("t1_w_after", int'(w), 1);
    chk("t1_cfg_ready_idle", int'(cfg_ready), 1);
    wait_idle("t1_idle");

    // Load delay 3; an offer made while busy must be ignored.
    cfg(8'd3);
    chg(1'b0, 1'b1, 3);
    cfg_valid = 1'b1;
    cfg_delay = 8'd7;
    repeat (2) begin
      chk("t2_cfg_ready_busy", int'(cfg_ready), 0);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    wait_idle("t2_idle_a");
    chg(1'b1, 1'b1, 3);
    wait_idle("t2_idle_b");

    // Requested delay 0 behaves as 1.
    cfg(8'd0);
    chg(1'b1, 1'b0, 1);
    wait_idle("t2_idle_zero");

`ifdef CONT_ASSIGN_DELAY_SCHED_INERTIAL_EN
    // Short pulse is swallowed; a long one passes through delayed by 5.
    cfg(8'd5);
    a = 1'b1;
    b = 1'b1;
    tick(1);
    chk("inr_pending_rise", int'(pending), 1);
    tick(1);
    a = 1'b0;
    tick(1);
    chk("inr_pending_glitch", int'(pending), 0);
    tick(10);
    chk("inr_w_unchanged", int'(w), 0);
    chg(1'b1, 1'b1, 5);
    tick(6);
    chg(1'b0, 1'b1, 5);
    chk("inr_pending_fall", int'(pending), 1);
    wait_idle("inr_idle");
    chk("inr_overflow", int'(overflow), 0);
`else
    // Transport pulse of width 2 keeps its width.
    cfg(8'd10);
    chg(1'b1, 1'b1, 10);
    tick(1);
    chg(1'b0, 1'b1, 10);
    chk("t3_pending_two", int'(pending), 2);
    wait_idle("t3_idle");

    // Six toggles into a 4-deep queue: the last two overwrite the tail.
    begin
      int   k;
      ev_t  e;
      k = cyc + 1;
      e.edge_n = k + 10; e.val = 1'b1; sbq.push_back(e);
      e.edge_n = k + 11; e.val = 1'b0; sbq.push_back(e);
      e.edge_n = k + 12; e.val = 1'b1; sbq.push_back(e);
      e.edge_n = k + 15; e.val = 1'b0; sbq.push_back(e);
      for (int i = 0; i < 6; i++) begin
        a = (i % 2 == 0);
        b = 1'b1;
        @(negedge clk);
      end
      a = 1'b0;
    end
    chk("t4_pending_full", int'(pending), 4);
    chk("t4_overflow_set", int'(overflow), 1);
    wait_idle("t4_idle");
    chk("t4_w_final", int'(w), 0);
    chk("t4_overflow_sticky", int'(overflow), 1);
    cfg(8'd10);
    chk("t4_overflow_cleared", int'(overflow), 0);
`endif

    // Asynchronous reset in the middle of a busy period.
    cfg(8'd4);
    chg(1'b1, 1'b1, 4);
    wait_idle("t5_idle_pre");
    a = 1'b0; tick(1);
    a = 1'b1; tick(1);
    a = 1'b0; tick(1);
    chk("t5_pending_pre", int'(pending), EXP_RST_PEND);
    chk("t5_w_pre", int'(w), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_w", int'(w), 0);
    chk("t5_rst_pending", int'(pending), 0);
    chk("t5_rst_overflow", int'(overflow), 0);
    chk("t5_rst_cfg_ready", int'(cfg_ready), 1);
    sbq.delete();
    a = 1'b0;
    b = 1'b0;
    tick(2);
    #2;
    rst_n = 1'b1;
    tick(20);
    chk("t5_w_quiet", int'(w), 0);
    chk("t5_pending_quiet", int'(pending), 0);

    // After reset the delay is back to 10.
    chg(1'b1, 1'b1, 10);
    wait_idle("t6_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
